// File: rtl/config_loader.sv
// rtl/config_loader.sv - serial master that writes or non-destructively reads the ConfigStore shift chain
module config_loader #(
    parameter int WIDTH   = 18,
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             writeEn,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] readData,
    output logic             serialEn,
    output logic             serialIn,
    input  logic             serialOut
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] txShift;
    logic [WIDTH-1:0] rxShift;
    logic [WIDTH-1:0] rxNext;
    logic             mode;
    logic [CNT_W-1:0] bitCnt;
    logic [DIV_W-1:0] divCnt;
    logic             shiftNow;
    logic             lastBit;

    always_comb begin
        stateNext = state;
        shiftNow  = (state == SHIFT) && (divCnt == DIV_LAST);
        lastBit   = shiftNow && (bitCnt == BIT_LAST);
        // The final bit arrives on the same edge that loads readData.
        rxNext    = {rxShift[WIDTH-2:0], serialOut};
        case (state)
            IDLE:    if (start) stateNext = SHIFT;
            SHIFT:   if (lastBit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txShift  <= '0;
            rxShift  <= '0;
            readData <= '0;
            mode     <= 1'b0;
            bitCnt   <= '0;
            divCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        txShift <= writeData;
                        mode    <= writeEn;
                        bitCnt  <= '0;
                        divCnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (shiftNow) begin
                        divCnt  <= '0;
                        rxShift <= rxNext;
                        txShift <= {txShift[WIDTH-2:0], 1'b0};
                        bitCnt  <= bitCnt + CNT_W'(1);
                        if (lastBit) readData <= rxNext;
                    end else begin
                        divCnt <= divCnt + DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign serialEn = shiftNow;
    // Recirculate mode feeds the store's MSB straight back so a read leaves it intact.
    assign serialIn = (state == SHIFT) && (mode ? txShift[WIDTH-1] : serialOut);

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - scoreboard bench for config_loader with behavioural ConfigStore chains
module tb_config_loader;
    localparam int W = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         startA, weA, busyA, doneA, enA, sinA, soutA;
    logic [W-1:0] wdA, rdA;
    logic         startB, weB, busyB, doneB, enB, sinB, soutB;
    logic [W-1:0] wdB, rdB;
    logic [W-1:0] storeA = '0;
    logic [W-1:0] storeB = '0;

    config_loader #(.WIDTH(W), .CLK_DIV(1)) dutA (
        .clk(clk), .reset(reset), .start(startA), .writeEn(weA), .writeData(wdA),
        .busy(busyA), .done(doneA), .readData(rdA),
        .serialEn(enA), .serialIn(sinA), .serialOut(soutA)
    );

    config_loader #(.WIDTH(W), .CLK_DIV(3)) dutB (
        .clk(clk), .reset(reset), .start(startB), .writeEn(weB), .writeData(wdB),
        .busy(busyB), .done(doneB), .readData(rdB),
        .serialEn(enB), .serialIn(sinB), .serialOut(soutB)
    );

    assign soutA = storeA[W-1];
    assign soutB = storeB[W-1];
    always @(posedge clk) if (enA) storeA <= {storeA[W-2:0], sinA};
    always @(posedge clk) if (enB) storeB <= {storeB[W-2:0], sinB};

    int nVec = 0;
    int nMis = 0;
    logic [W-1:0] expA[$];
    logic [W-1:0] expB[$];
    logic [W-1:0] eA, eB;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (doneA === 1'b1) begin
            if (expA.size() == 0) check("A unexpected done", 1, 0);
            else begin
                eA = expA.pop_front();
                check("A readData", rdA, eA);
            end
        end
        if (doneB === 1'b1) begin
            if (expB.size() == 0) check("B unexpected done", 1, 0);
            else begin
                eB = expB.pop_front();
                check("B readData", rdB, eB);
            end
        end
    end

    task automatic xferA(input logic we, input logic [W-1:0] data, input logic [W-1:0] expRd,
                         input int glitchAt, input int abortAt, input logic [W-1:0] expStore,
                         input string tag);
        int doneCyc;
        int bad;
        @(negedge clk);
        startA = 1'b1; weA = we; wdA = data;
        if (abortAt < 0) expA.push_back(expRd);
        @(posedge clk);
        #1;
        startA = 1'b0; weA = ~we; wdA = ~data;
        doneCyc = -1;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n == glitchAt) begin startA = 1'b1; weA = 1'b1; wdA = 18'h00001; end
            if (n == glitchAt + 1) startA = 1'b0;
            if (n == abortAt) begin
                reset = 1'b1;
                #1;
                check({tag, " busy in reset"}, busyA, 0);
                check({tag, " serialEn in reset"}, enA, 0);
                check({tag, " done in reset"}, doneA, 0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (enA !== (n < W)) bad++;
            if (doneA === 1'b1) begin doneCyc = n; break; end
        end
        check({tag, " serialEn pattern"}, bad, 0);
        check({tag, " done latency"}, doneCyc, W);
        check({tag, " store"}, storeA, expStore);
        @(negedge clk);
        check({tag, " idle after done"}, {busyA, doneA}, 0);
    endtask

    initial begin
        int bad;
        int doneCyc;
        logic [W-1:0] dB;
        reset = 1'b1;
        startA = 0; weA = 0; wdA = '0;
        startB = 0; weB = 0; wdB = '0;
        repeat (3) @(negedge clk);
        check("A reset busy", busyA, 0);
        check("A reset done", doneA, 0);
        check("A reset serialEn", enA, 0);
        check("A reset serialIn", sinA, 0);
        check("A reset readData", rdA, 0);
        check("B reset outputs", {busyB, doneB, enB, sinB}, 0);
        check("B reset readData", rdB, 0);
        reset = 1'b0;
        @(negedge clk);

        xferA(1'b1, 18'h2A5C3, 18'h00000, -1, -1, 18'h2A5C3, "write1");
        check("clockConfig 1", storeA[5:0], 6'h03);
        check("adcScale 1", storeA[11:6], 6'h17);
        check("dacScale 1", storeA[17:12], 6'h2A);

        xferA(1'b1, 18'h15A3C, 18'h2A5C3, -1, -1, 18'h15A3C, "write2");
        check("clockConfig 2", storeA[5:0], 6'h3C);
        check("adcScale 2", storeA[11:6], 6'h28);
        check("dacScale 2", storeA[17:12], 6'h15);

        xferA(1'b0, 18'h3FFFF, 18'h15A3C, -1, -1, 18'h15A3C, "read1");
        xferA(1'b0, 18'h3FFFF, 18'h15A3C, -1, -1, 18'h15A3C, "read2");

        xferA(1'b1, 18'h2A5C3, 18'h15A3C, 5, -1, 18'h2A5C3, "busyStart");
        repeat (25) @(negedge clk);
        check("busyStart no second transfer", storeA, 18'h2A5C3);

        xferA(1'b1, 18'h15A3C, 18'h0, -1, 9, 18'h0, "abort");
        check("abort partial store", storeA, 18'h386AD);
        repeat (25) @(negedge clk);
        xferA(1'b1, 18'h2A5C3, 18'h386AD, -1, -1, 18'h2A5C3, "afterAbort");

        dB = 18'h2A5C3;
        @(negedge clk);
        startB = 1'b1; weB = 1'b1; wdB = dB;
        expB.push_back(18'h00000);
        @(posedge clk);
        #1;
        startB = 1'b0; wdB = '0;
        bad = 0;
        doneCyc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (enB !== (n < 3 * W && n % 3 == 2)) bad++;
            if (n < 3 * W && sinB !== dB[W - 1 - n / 3]) bad++;
            if (doneB === 1'b1) begin doneCyc = n; break; end
        end
        check("div3 serialEn/serialIn pattern", bad, 0);
        check("div3 done latency", doneCyc, 3 * W);
        check("div3 store", storeB, 18'h2A5C3);

        repeat (3) @(negedge clk);
        check("A scoreboard drained", expA.size(), 0);
        check("B scoreboard drained", expB.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
